// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requester pool and the arbiter.
interface rr_arbiter8_if;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       valid;
  logic       timeout;

  modport master (
    output enable, req, done,
    input  grant, grant_idx, valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_idx, valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way descending round-robin arbiter with hold timeout and a
// one-cycle turnaround gap between tenures.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave s
);

  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       last_idx, last_nx;
  logic [7:0]       grant_q, grant_nx;
  logic [2:0]       idx_q, idx_nx;
  logic             valid_q, valid_nx;
  logic             timeout_q, timeout_nx;

  logic [2:0]       cand;
  logic [2:0]       win_idx;
  logic             win_found;
  logic             rel_drop, rel_hold;

  // Winner search: last_idx-1 downward with wrap, last_idx itself checked last.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = last_idx - 3'(k);
      if (!win_found && s.req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    last_nx    = last_idx;
    grant_nx   = grant_q;
    idx_nx     = idx_q;
    valid_nx   = valid_q;
    timeout_nx = 1'b0;
    rel_drop   = !s.req[idx_q];
    rel_hold   = (cnt == CNT_W'(MAX_HOLD - 1));
    case (state)
      IDLE: begin
        if (s.enable && win_found) begin
          state_nx = OWNED;
          grant_nx = 8'b1 << win_idx;
          idx_nx   = win_idx;
          valid_nx = 1'b1;
          cnt_nx   = '0;
        end
      end
      OWNED: begin
        if (!s.enable) begin
          state_nx = IDLE;
          last_nx  = idx_q;
          grant_nx = '0;
          valid_nx = 1'b0;
        end else if (s.done || rel_drop || rel_hold) begin
          state_nx   = GAP;
          last_nx    = idx_q;
          grant_nx   = '0;
          valid_nx   = 1'b0;
          timeout_nx = rel_hold && !s.done && !rel_drop;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        valid_nx = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_idx  <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last_idx  <= last_nx;
      grant_q   <= grant_nx;
      idx_q     <= idx_nx;
      valid_q   <= valid_nx;
      timeout_q <= timeout_nx;
    end
  end

  assign s.grant     = grant_q;
  assign s.grant_idx = idx_q;
  assign s.valid     = valid_q;
  assign s.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with a tenure-level reference model.
module tb_rr_arbiter8;
  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n;
  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, for how many cycles so far,
  // and how many forced-idle cycles remain after a release.
  int m_owner;   // -1 when nobody owns
  int m_tenure;  // cycles the current grant has been visible
  int m_cool;    // turnaround cycles still to pass
  int m_last;
  int m_idx;
  bit m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_tenure = 0; m_cool = 0; m_last = 0; m_idx = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_owner >= 0) begin
        bit drop, expire;
        drop   = !bus.req[m_owner];
        expire = (m_tenure == MAX_HOLD);
        if (!bus.enable) begin
          m_last = m_owner; m_owner = -1; m_cool = 0;
        end else if (bus.done || drop || expire) begin
          m_last = m_owner; m_owner = -1; m_cool = 1;
          m_to = expire && !bus.done && !drop;
        end else begin
          m_tenure++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (bus.enable && bus.req != 0) begin
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_last - k + 8) % 8;
          if (m_owner < 0 && bus.req[c]) m_owner = c;
        end
        m_idx = m_owner;
        m_tenure = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("grant",     int'(bus.grant),     (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("grant_idx", int'(bus.grant_idx), m_idx);
    chk("valid",     int'(bus.valid),     (m_owner >= 0) ? 1 : 0);
    chk("timeout",   int'(bus.timeout),   int'(m_to));
  end

  // Wait (bounded) on falling edges for a visible grant.
  task automatic get_grant(input string name, input int exp_idx);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.valid) found = 1;
    end
    if (!found) chk({name, "_wait"}, 0, 1);
    else        chk(name, int'(bus.grant_idx), exp_idx);
  endtask

  initial begin
    int seq [4];
    int exp_seq [4];
    int cnt;
    exp_seq = '{7, 2, 0, 7};

    rst_n = 1'b0; bus.enable = 1'b0; bus.req = '0; bus.done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_idx",   int'(bus.grant_idx), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_tmo",   int'(bus.timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First arbitration after reset: highest index wins, 1-cycle latency.
    bus.enable = 1'b1; bus.req = 8'b1000_0101;
    @(posedge clk); #1;
    chk("first_grant", int'(bus.grant), 8'h80);
    chk("first_idx",   int'(bus.grant_idx), 7);
    chk("first_valid", int'(bus.valid), 1);

    // Rotation with done pulses: 7, 2, 0, 7.
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      if (t > 0) get_grant("rot_grant", exp_seq[t]);
      seq[t] = int'(bus.grant_idx);
      bus.done = 1'b1;
      @(negedge clk);
      bus.done = 1'b0;
    end
    for (int t = 0; t < 4; t++) chk("rot_seq", seq[t], exp_seq[t]);

    // Single requester without done: held exactly MAX_HOLD cycles then timeout.
    bus.req = 8'b0000_0010;
    get_grant("hold_grant", 1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.valid) break;
      cnt++;
    end
    chk("hold_cycles", cnt, MAX_HOLD);
    chk("hold_timeout", int'(bus.timeout), 1);
    get_grant("regrant", 1);

    // done, req drop and hold expiry together: plain release, no timeout.
    repeat (MAX_HOLD - 1) @(negedge clk);
    chk("coinc_still_valid", int'(bus.valid), 1);
    bus.done = 1'b1; bus.req = '0;
    @(negedge clk);
    bus.done = 1'b0;
    chk("coinc_valid", int'(bus.valid), 0);
    chk("coinc_tmo",   int'(bus.timeout), 0);

    // enable drop mid-tenure: straight to IDLE, re-grant one cycle later.
    bus.req = 8'b1000_0101;
    get_grant("en_grant", 0);
    repeat (2) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_off_valid", int'(bus.valid), 0);
    chk("en_off_tmo",   int'(bus.timeout), 0);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("en_on_valid", int'(bus.valid), 1);
    chk("en_on_idx",   int'(bus.grant_idx), 7);

    // Asynchronous reset mid-grant.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", int'(bus.grant), 0);
    chk("arst_valid", int'(bus.valid), 0);
    chk("arst_tmo",   int'(bus.timeout), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    get_grant("post_rst", 7);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Issues a one-hot grant plus the encoded index, holds it until the owner signals done, and rotates priority after every release.
- A hold-timeout prevents one requester from keeping the resource indefinitely.
- Sits in front of the shared datapath; grant_idx drives its select mux.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..255.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arbitration enable; low forces release and idle.
- req  in  8  request vector, one bit per requester, level-sensitive.
- done  in  1  single-cycle pulse from the current owner ending its tenure.
- grant  out  8  one-hot grant, registered.
- grant_idx  out  3  binary index of granted requester, registered.
- valid  out  1  high while grant is non-zero.
- timeout  out  1  one-cycle pulse when a grant is forcibly released.

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant=0, grant_idx=0, valid=0, timeout=0.
  - state=IDLE, hold counter=0, last_idx=0.
- States: IDLE, OWNED, GAP.
- IDLE:
  - If enable=1 and req!=0, pick the winner and move to OWNED on that edge.
  - grant, grant_idx and valid are registered on that same edge, so latency is 1 cycle from sampled req to visible grant.
  - Hold counter clears on entry to OWNED.
- Winner selection (descending round-robin):
  - Search order starts at last_idx-1 and walks downward, wrapping 0->7; last_idx itself is checked last.
  - First set req bit in that order wins.
  - After reset last_idx=0, so the first search order is 7,6,...,1,0 (plain highest-index priority).
- OWNED:
  - grant holds stable and the hold counter increments every cycle.
  - Release conditions, evaluated each edge:
    - (a) done=1;
    - (b) req[grant_idx]=0;
    - (c) counter = MAX_HOLD-1;
    - (d) enable=0.
  - On any release: last_idx<=grant_idx, grant=0, valid=0, next state GAP.
  - Exception: enable=0 goes directly to IDLE.
  - timeout=1 for exactly one cycle only when (c) is the sole cause. If (c) coincides with (a) or (b), it is a normal release with no timeout pulse.
- GAP: one mandatory idle turnaround cycle with all grants low, then IDLE. Back-to-back grants are therefore separated by at least one cycle.
- done outside OWNED is ignored. req changes on non-owner bits during OWNED are ignored.
- Exactly one grant bit is ever high; grant_idx always equals the encoded grant while valid=1, and holds its last value while valid=0.
- enable low in IDLE or GAP: stay in or return to IDLE; last_idx is preserved.
- Asynchronous reset mid-grant: outputs clear immediately, with no timeout pulse.

Test Plan:
- Reset, enable=1, req=8'b1000_0101 -> one cycle later grant=8'b1000_0000, grant_idx=7, valid=1.
- Same req held; owner pulses done each tenure -> grant sequence 7,2,0,7 with one GAP cycle of grant=0 between each.
- req=8'b0000_0010 held, no done -> grant[1] for exactly 16 cycles, then timeout pulse 1 cycle, GAP, re-grant to 1.
- Owner drops its req bit while done=1 and counter=MAX_HOLD-1 all in the same cycle -> single release, timeout stays 0.
- enable deasserted during OWNED -> grant=0 next edge, state IDLE, no GAP; re-enable with the same req -> the next winner follows the rotated order.
- rst_n pulsed low asynchronously mid-grant -> grant/valid/timeout go 0 without waiting for a clock edge; the next arbitration again favours index 7.
